ex_stage_mc: RTL

- Parametrised, registered execute stage for the pipelined ARMv8 core.
- Selects operands with 3-way forwarding muxes and an immediate select, then computes an ALU result.
- Writes the result, zero flag and destination register into an internal EX/MEM register.
- Adds an iterative multi-cycle multiplier (MUL). While it runs, the stage stalls the front of the pipeline through a stall output.

---
 rtl/ex_stage_mc_pkg.sv | 26 ++
 rtl/ex_stage_mc_mul_iter.sv | 67 ++++++
 rtl/ex_stage_mc.sv | 117 +++++++++++
 3 files changed

// File: rtl/ex_stage_mc_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, forwarding
// selects and the multiplier FSM state type.
package ex_stage_mc_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_LSL  = 4'b0011;
  localparam logic [3:0] ALU_LSR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/ex_stage_mc_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle;
// returns the low DATA_W bits of the unsigned product.
module mul_iter
  import ex_stage_mc_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output mul_state_t        state
);

  localparam int STEPS = DATA_W / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] a_sh;
  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] partial;

  always_comb begin
    partial = {{(DATA_W-MUL_STEP){1'b0}}, b_sh[MUL_STEP-1:0]} * a_sh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MUL_IDLE;
      count   <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      product <= '0;
    end else if (abort) begin
      state <= MUL_IDLE;
    end else begin
      case (state)
        MUL_IDLE: if (start) begin
          state   <= MUL_RUN;
          count   <= CNT_W'(STEPS);
          a_sh    <= a;
          b_sh    <= b;
          product <= '0;
        end
        MUL_RUN: begin
          product <= product + partial;
          a_sh    <= a_sh << MUL_STEP;
          b_sh    <= b_sh >> MUL_STEP;
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= MUL_DONE;
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  assign busy = (state == MUL_RUN);
  assign done = (state == MUL_DONE);

endmodule

// File: rtl/ex_stage_mc.sv
// Registered execute stage: forwarding muxes, ALU, EX/MEM register and an
// iterative MUL that stalls the front of the pipe while it runs.
module ex_stage_mc
  import ex_stage_mc_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MUL_STEP = 1,
  parameter int REG_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] sign_extend_in,
  input  logic              alu_src,
  input  logic [3:0]        alu_ctrl,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] ex_mem_fwd,
  input  logic [DATA_W-1:0] wb_fwd,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic [REG_W-1:0]  rd_out,
  output logic [DATA_W-1:0] store_data
);

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] reg_val,
                                                input logic [DATA_W-1:0] mem_val,
                                                input logic [DATA_W-1:0] wb_val);
    case (sel)
      FWD_REG: return reg_val;
      FWD_MEM: return mem_val;
      FWD_WB:  return wb_val;
      default: return '0;
    endcase
  endfunction

  logic [DATA_W-1:0] op_a, op_b, b_store, alu_out, mul_product;
  logic [REG_W-1:0]  mul_rd;
  logic              mul_start, mul_busy, mul_done;
  mul_state_t        mul_state;

  always_comb begin
    op_a    = fwd_mux(forward_a, read_data_1, ex_mem_fwd, wb_fwd);
    op_b    = fwd_mux(forward_b, alu_src ? sign_extend_in : read_data_2, ex_mem_fwd, wb_fwd);
    b_store = fwd_mux(forward_b, read_data_2, ex_mem_fwd, wb_fwd);
  end

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      ALU_AND:  alu_out = op_a & op_b;
      ALU_ORR:  alu_out = op_a | op_b;
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_PASS: alu_out = op_b;
      ALU_NOR:  alu_out = ~(op_a | op_b);
      ALU_LSL:  alu_out = op_a << op_b[5:0];
      ALU_LSR:  alu_out = op_a >> op_b[5:0];
      default:  alu_out = '0;
    endcase
  end

  // A MUL stalls in the very cycle it is presented, before the FSM leaves IDLE.
  assign mul_start = (mul_state == MUL_IDLE) && in_valid && !flush && (alu_ctrl == ALU_MUL);
  assign stall     = !reset && (mul_start || mul_busy);

  mul_iter #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (flush),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product),
    .state   (mul_state)
  );

  // The DONE cycle still sees the held MUL on the inputs; it is ignored here.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b0;
      rd_out     <= '0;
      store_data <= '0;
      mul_rd     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      alu_result <= mul_product;
      zero       <= (mul_product == '0);
      rd_out     <= mul_rd;
    end else if (mul_start) begin
      out_valid <= 1'b0;
      mul_rd    <= rd_in;
    end else if (mul_busy || !in_valid) begin
      out_valid <= 1'b0;
    end else begin
      out_valid  <= 1'b1;
      alu_result <= alu_out;
      zero       <= (alu_out == '0);
      rd_out     <= rd_in;
      store_data <= b_store;
    end
  end

endmodule
